// File: rtl/multi_debounce_ctrl_pkg.sv
// ============================================================================
// Module : multi_debounce_ctrl_pkg
// Brief  : Shared debounce FSM state type, default parameters, width helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multi_debounce_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } deb_state_t;

    localparam int C_DEF_N_CH         = 4;
    localparam int C_DEF_TICK_MAX     = 500000;
    localparam int C_DEF_STABLE_TICKS = 4;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_debounce_ctrl_tick_gen.sv
// ============================================================================
// Module : tick_gen
// Brief  : Free-running 0..TICK_MAX counter; tick is high while count==TICK_MAX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen
    import multi_debounce_ctrl_pkg::*;
#(
    parameter int TICK_MAX = C_DEF_TICK_MAX
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             c_W   = cnt_width(TICK_MAX);
    localparam logic [c_W-1:0] c_MAX = c_W'(TICK_MAX);
    localparam logic [c_W-1:0] c_ONE = c_W'(1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tick = (r_cnt == c_MAX);

endmodule

`default_nettype wire

// File: rtl/multi_debounce_ctrl.sv
// ============================================================================
// Module : multi_debounce_ctrl
// Brief  : N_CH independent button debouncers sharing one sample tick.
//          Define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_debounce_ctrl
    import multi_debounce_ctrl_pkg::*;
#(
    parameter int N_CH         = C_DEF_N_CH,
    parameter int TICK_MAX     = C_DEF_TICK_MAX,
    parameter int STABLE_TICKS = C_DEF_STABLE_TICKS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic            tick
);

    localparam int              c_SW     = cnt_width(STABLE_TICKS);
    localparam logic [c_SW-1:0] c_STABLE = c_SW'(STABLE_TICKS);
    localparam logic [c_SW-1:0] c_ONE    = c_SW'(1);

    logic            w_tick;
    logic [N_CH-1:0] w_sample;

    tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign tick = w_tick;

`ifdef DEBOUNCE_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = btn_in;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        deb_state_t      r_state;
        logic [c_SW-1:0] r_cnt;
        logic            r_level;
        logic            r_press;
        logic            r_rel;

        // A bounce takes priority over a coincident tick, and the tick on the
        // IDLE->CHK edge is ignored, so every check starts from a full tick.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= IDLE_LO;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_press <= 1'b0;
                r_rel   <= 1'b0;
                case (r_state)
                    IDLE_LO: begin
                        if (w_sample[i]) begin
                            r_state <= CHK_HI;
                            r_cnt   <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!w_sample[i]) begin
                            r_state <= IDLE_LO;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            if ((r_cnt + c_ONE) == c_STABLE) begin
                                r_state <= IDLE_HI;
                                r_cnt   <= '0;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                    end
                    IDLE_HI: begin
                        if (!w_sample[i]) begin
                            r_state <= CHK_LO;
                            r_cnt   <= '0;
                        end
                    end
                    CHK_LO: begin
                        if (w_sample[i]) begin
                            r_state <= IDLE_HI;
                            r_cnt   <= '0;
                        end else if (w_tick) begin
                            if ((r_cnt + c_ONE) == c_STABLE) begin
                                r_state <= IDLE_LO;
                                r_cnt   <= '0;
                                r_level <= 1'b0;
                                r_rel   <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE_LO;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]     = r_level;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_rel;
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_debounce_ctrl.sv
// ============================================================================
// Module : tb_multi_debounce_ctrl
// Brief  : Scoreboard bench for multi_debounce_ctrl (TICK_MAX=3, STABLE_TICKS=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_debounce_ctrl;

    localparam int c_N_CH = 4;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lvl;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_N_CH-1:0] btn_in = '0;
    logic [c_N_CH-1:0] btn_level;
    logic [c_N_CH-1:0] press_pulse;
    logic [c_N_CH-1:0] release_pulse;
    logic              tick;

    int  cyc    = 0;
    int  errs   = 0;
    int  n_chk  = 0;
    ev_t exp_q[$];

    multi_debounce_ctrl #(
        .N_CH         (c_N_CH),
        .TICK_MAX     (3),
        .STABLE_TICKS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .tick          (tick)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first cycle after the last edge that sampled rst=1.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Monitor: tick against its period, pulses against the expected-event queue.
    always @(negedge clk) begin
        ev_t e;
        n_chk++;
        if (tick !== ((cyc % 4) == 3)) begin
            errs++;
            $display("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, ((cyc % 4) == 3));
        end
        if ((press_pulse | release_pulse) !== 4'b0000) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b lvl=%b",
                         cyc, press_pulse, release_pulse, btn_level);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || press_pulse !== e.press ||
                    release_pulse !== e.rel || btn_level !== e.lvl) begin
                    errs++;
                    $display("FAIL pulse_event got cyc=%0d press=%b rel=%b lvl=%b want cyc=%0d press=%b rel=%b lvl=%b",
                             cyc, press_pulse, release_pulse, btn_level,
                             e.cyc, e.press, e.rel, e.lvl);
                end
            end
        end
    end

    task automatic chk_zero(input string name);
        n_chk++;
        if ({btn_level, press_pulse, release_pulse, tick} !== '0) begin
            errs++;
            $display("FAIL %s cyc=%0d got lvl=%b press=%b rel=%b tick=%b want all zero",
                     name, cyc, btn_level, press_pulse, release_pulse, tick);
        end
    endtask

    task automatic chk_level(input string name, input logic [3:0] want);
        n_chk++;
        if (btn_level !== want) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, btn_level, want);
        end
    endtask

    // Returns with the caller at the negedge of cycle 0, rst just released.
    task automatic do_reset();
        rst    = 1'b1;
        btn_in = '0;
        repeat (3) begin
            @(negedge clk);
            chk_zero("reset_hold");
        end
        rst = 1'b0;
    endtask

    function automatic logic [3:0] seg1_vec(input int k);
        logic [3:0] v;
        v    = '0;
        v[0] = ((k >= 4) && (k < 30)) || (k >= 48);
        v[1] = (k >= 4) && (k <= 43) && ((((k - 4) / 3) % 2) == 0);
        v[3] = (k >= 48);
        return v;
    endfunction

    initial begin
        // Ch0 held from 4: ticks 7,11 -> press at 12. Released from 30: ticks 31,35 -> 36.
        // Ch0+ch3 from 48: ticks 51,55 -> press at 56. Ch1 chatter never qualifies.
        exp_q.push_back('{cyc: 12, press: 4'b0001, rel: 4'b0000, lvl: 4'b0001});
        exp_q.push_back('{cyc: 36, press: 4'b0000, rel: 4'b0001, lvl: 4'b0000});
        exp_q.push_back('{cyc: 56, press: 4'b1001, rel: 4'b0000, lvl: 4'b1001});
        do_reset();
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) @(negedge clk);
            btn_in = seg1_vec(k);
        end
        @(negedge clk);
        chk_level("level_after_seg1", 4'b1001);

        // Ch2 reaches count 1 at tick 3, then a 1-cycle reset at cycle 5 aborts it;
        // after release it re-qualifies on ticks 3,7 -> press at fresh cycle 8.
        do_reset();
        exp_q.push_back('{cyc: 8, press: 4'b0100, rel: 4'b0000, lvl: 4'b0100});
        btn_in = 4'b0100;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_check_reset");
        rst = 1'b0;
        repeat (14) @(negedge clk);
        chk_level("level_after_seg2", 4'b0100);

        n_chk++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL missing_events got_left=%0d want=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/multi_debounce_ctrl.md
MULTI_DEBOUNCE_CTRL -- requirements
Module: multi_debounce_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, range 1..16.
REQ-002 Parameter TICK_MAX, default 500000: terminal count of the shared sample-tick counter; tick period P = TICK_MAX+1 cycles.
REQ-003 Parameter STABLE_TICKS, default 4: consecutive stable ticks required to accept a level change, range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 btn_in  input  N_CH  raw, bouncy button inputs; asynchronous to clk.
REQ-007 btn_level  output  N_CH  debounced level per channel, registered.
REQ-008 press_pulse  output  N_CH  one-cycle pulse on an accepted 0->1 change, registered.
REQ-009 release_pulse  output  N_CH  one-cycle pulse on an accepted 1->0 change, registered.
REQ-010 tick  output  1  shared sample tick, one cycle high every P cycles, for observation.

Function
REQ-011 Tick counter shall count 0..TICK_MAX; tick=1 in the cycle the count equals TICK_MAX, after which the count wraps to 0; width = clog2(TICK_MAX+1).
REQ-012 Each channel shall run its own FSM with states IDLE_LO, CHK_HI, IDLE_HI and CHK_LO, plus a stable counter of width clog2(STABLE_TICKS+1).
REQ-013 IDLE_LO with sampled input 1 -> CHK_HI with the counter cleared; sampled input 0 -> stay.
REQ-014 CHK_HI with sampled input 0 -> IDLE_LO (bounce rejected), with no pulse and the counter cleared.
REQ-015 CHK_HI with sampled input 1 and tick -> counter increments; when the increment reaches STABLE_TICKS -> IDLE_HI.
REQ-016 Entering IDLE_HI shall set btn_level=1 and press_pulse=1 in the same cycle; press_pulse shall clear the following cycle.
REQ-017 The IDLE_HI, CHK_LO and IDLE_LO transitions shall mirror REQ-013..016 with inverted input, and release_pulse shall be asserted on entering IDLE_LO from CHK_LO.
REQ-018 A tick occurring in the same cycle as the IDLE->CHK transition shall not be counted.
REQ-019 A bounce and a tick in the same cycle: the bounce shall win; the state returns to IDLE and the counter does not increment.
REQ-020 Acceptance latency from the first stable sample to the btn_level change shall be between (STABLE_TICKS-1)*P+1 and STABLE_TICKS*P cycles.
REQ-021 Channels shall be fully independent; simultaneous pulses on several channels are legal.
REQ-022 press_pulse and release_pulse of a channel shall never be high in the same cycle.

Reset
REQ-023 While rst=1: tick counter=0, tick=0, all FSMs in IDLE_LO, stable counters=0, btn_level=0, press_pulse=0, release_pulse=0.
REQ-024 Reset asserted mid-check shall abort the check with no pulse; after release, a held button shall re-qualify from IDLE_LO.
REQ-025 After reset release, the first tick shall occur in cycle TICK_MAX, counting the first cycle after release as cycle 0.

Configuration
REQ-026 Macro DEBOUNCE_SYNC_EN defined: each btn_in bit shall pass through a 2-flop synchronizer, reset to 0, before the FSM; this adds 2 cycles of latency.
REQ-027 Macro DEBOUNCE_SYNC_EN undefined: the FSMs shall sample btn_in directly, and the caller guarantees synchronous inputs.

Structure
REQ-028 A shared package shall hold the FSM state typedef (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO) and the default parameter constants.
REQ-029 The tick counter shall be a sub-module named tick_gen with parameter TICK_MAX, ports clk/rst, and output tick; the per-channel FSMs shall be generated inside multi_debounce_ctrl.

Verification (TICK_MAX=3, STABLE_TICKS=2, sync disabled, P=4, ticks at cycles 3, 7, 11, ...)
REQ-030 Reset release, btn_in=0 for 20 cycles -> tick high exactly at cycles 3, 7, 11, 15, 19; all outputs otherwise 0.
REQ-031 btn_in[0]=1 from cycle 4, held -> CHK_HI at cycle 5; ticks at 7 and 11 counted; btn_level[0]=1 and press_pulse[0]=1 at cycle 12 only.
REQ-032 btn_in[1] toggles 1/0 every 3 cycles for 40 cycles -> btn_level[1] stays 0 and no pulses occur.
REQ-033 Channel 0 high and stable, then btn_in[0]=0 from cycle 30 -> release_pulse[0] for exactly one cycle within 5..8 cycles; btn_level[0]=0 thereafter.
REQ-034 rst asserted for 1 cycle while channel 2 is in CHK_HI with counter=1 -> no press pulse; a held input gives press_pulse[2] only after 2 fresh ticks.
REQ-035 Channels 0 and 3 rise in the same cycle -> press_pulse[0] and press_pulse[3] are asserted in the same cycle.
